seq_multiplier_16: RTL and testbench

//  Multi-cycle 16x16 -> 32-bit multiplier for the CPU's MUL instruction, built on the datapath's 16-bit carry-lookahead adder.

---
 rtl/seq_multiplier_16.sv | 134 +++++++++++++
 tb/tb_seq_multiplier_16.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_multiplier_16.sv
// Multi-cycle 16x16 -> 32 shift-add multiplier (unsigned / two's complement) driving
// a 16-bit carry-lookahead adder once per iteration; result lands in hi/lo at FIX.

module cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       gg,
    output logic       pg
);
    logic [3:0] g, p, c;

    assign g    = a & b;
    assign p    = a ^ b;
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    assign sum  = p ^ c;
    assign gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    assign pg   = &p;
endmodule

module cla16 (
    input  logic [15:0] ra,
    input  logic [15:0] rb,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);
    logic [3:0] gg, pg;
    logic [4:0] gc;

    // second-level lookahead across the four nibble groups
    assign gc[0] = cin;
    assign gc[1] = gg[0] | (pg[0] & cin);
    assign gc[2] = gg[1] | (pg[1] & gg[0]) | (pg[1] & pg[0] & cin);
    assign gc[3] = gg[2] | (pg[2] & gg[1]) | (pg[2] & pg[1] & gg[0])
                 | (pg[2] & pg[1] & pg[0] & cin);
    assign gc[4] = gg[3] | (pg[3] & gg[2]) | (pg[3] & pg[2] & gg[1])
                 | (pg[3] & pg[2] & pg[1] & gg[0]) | (pg[3] & pg[2] & pg[1] & pg[0] & cin);
    assign cout  = gc[4];

    for (genvar i = 0; i < 4; i++) begin : g_grp
        cla4 u_cla4 (
            .a   (ra[4*i +: 4]),
            .b   (rb[4*i +: 4]),
            .cin (gc[i]),
            .sum (sum[4*i +: 4]),
            .gg  (gg[i]),
            .pg  (pg[i])
        );
    end
endmodule

module seq_multiplier_16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t               state, state_nxt;
    logic [WIDTH-1:0]     mcand, acc, mplr, sum;
    logic [3:0]           cnt;
    logic                 neg, cout, accept, last_iter;
    logic [2*WIDTH-1:0]   product, fixed;

    cla16 u_add (
        .ra   (acc),
        .rb   (mcand),
        .cin  (1'b0),
        .sum  (sum),
        .cout (cout)
    );

    assign accept    = start && (state == IDLE || state == DONE);
    assign last_iter = (cnt == 4'(WIDTH-1));
    assign product   = {acc, mplr};
    assign fixed     = neg ? (~product + (2*WIDTH)'(1)) : product;
    assign busy      = (state == CALC) || (state == FIX);
    assign done      = (state == DONE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = CALC;
            CALC:    if (last_iter) state_nxt = FIX;
            FIX:     state_nxt = DONE;
            DONE:    state_nxt = accept ? CALC : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mcand <= '0;
            acc   <= '0;
            mplr  <= '0;
            cnt   <= '0;
            neg   <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else if (accept) begin
            // operate on magnitudes; sign is reapplied once in FIX
            neg   <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
            mcand <= (signed_op & a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
            mplr  <= (signed_op & b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
            acc   <= '0;
            cnt   <= '0;
        end else if (state == CALC) begin
            if (mplr[0]) {acc, mplr} <= {cout, sum, mplr[WIDTH-1:1]};
            else         {acc, mplr} <= {1'b0, acc, mplr[WIDTH-1:1]};
            cnt <= cnt + 4'd1;
        end else if (state == FIX) begin
            {hi, lo} <= fixed;
        end
    end
endmodule

// File: tb/tb_seq_multiplier_16.sv
// Self-checking bench for seq_multiplier_16: directed corner cases, random ops
// against an arithmetic reference, start-while-busy, restart-in-DONE and async reset.

module tb_seq_multiplier_16;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        signed_op;
    logic [15:0] a, b;
    logic        busy, done;
    logic [15:0] hi, lo;

    int total = 0;
    int bad   = 0;

    seq_multiplier_16 #(.WIDTH(16)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .signed_op (signed_op),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_mul(input logic [15:0] x, input logic [15:0] y,
                                            input logic s);
        longint sx, sy;
        sx = s ? longint'($signed(x)) : longint'(x);
        sy = s ? longint'($signed(y)) : longint'(y);
        return 32'(sx * sy);
    endfunction

    // Issues one op and returns at the negedge where done is first seen.
    task automatic run_op(input logic [15:0] ia, input logic [15:0] ib, input logic is,
                          output logic [31:0] res, output int nbusy, output int ncyc,
                          output bit tmo);
        @(negedge clk);
        start = 1'b1; a = ia; b = ib; signed_op = is;
        @(negedge clk);
        start = 1'b0; a = 16'($urandom); b = 16'($urandom); signed_op = 1'($urandom);
        ncyc = 1; nbusy = 0;
        while (!done && ncyc < 40) begin
            if (busy) nbusy++;
            @(negedge clk);
            ncyc++;
        end
        tmo = !done;
        res = {hi, lo};
    endtask

    task automatic test_reset();
        total++;
        if ({busy, done, hi, lo} !== 34'd0) begin
            bad++;
            $display("FAIL reset_state: got busy=%0b done=%0b hi=%h lo=%h, want all 0",
                     busy, done, hi, lo);
        end
    endtask

    task automatic test_directed();
        logic [15:0] ta [7] = '{16'd3, 16'hFFFF, 16'hFFFD, 16'hFFFF, 16'h8000, 16'h0000, 16'h8000};
        logic [15:0] tb [7] = '{16'd5, 16'hFFFF, 16'h0007, 16'hFFFF, 16'h8000, 16'h8000, 16'h0001};
        logic        ts [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [31:0] te [7] = '{32'h0000_000F, 32'hFFFE_0001, 32'hFFFF_FFEB, 32'h0000_0001,
                                32'h4000_0000, 32'h0000_0000, 32'hFFFF_8000};
        logic [31:0] res;
        int nbusy, ncyc;
        bit tmo;
        for (int i = 0; i < 7; i++) begin
            run_op(ta[i], tb[i], ts[i], res, nbusy, ncyc, tmo);
            total++;
            if (tmo) begin
                bad++;
                $display("FAIL directed_timeout[%0d]: no done within %0d cycles", i, ncyc);
            end
            total++;
            if (res !== te[i]) begin
                bad++;
                $display("FAIL directed_result[%0d]: %h*%h s=%0b got %h want %h",
                         i, ta[i], tb[i], ts[i], res, te[i]);
            end
            total++;
            if (ncyc !== 18 || nbusy !== 17) begin
                bad++;
                $display("FAIL directed_latency[%0d]: got done@%0d busy=%0d want 18/17",
                         i, ncyc, nbusy);
            end
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL done_pulse: done still %0b one cycle later, want 0", done);
        end
    endtask

    task automatic test_random();
        logic [15:0] ra, rb;
        logic        rs;
        logic [31:0] res, exp;
        int nbusy, ncyc;
        bit tmo;
        for (int i = 0; i < 40; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (i % 8 == 0) ra = 16'h8000;
            if (i % 8 == 1) rb = 16'hFFFF;
            rs = 1'($urandom);
            exp = ref_mul(ra, rb, rs);
            run_op(ra, rb, rs, res, nbusy, ncyc, tmo);
            total++;
            if (tmo || res !== exp) begin
                bad++;
                $display("FAIL random[%0d]: %h*%h s=%0b got %h want %h tmo=%0b",
                         i, ra, rb, rs, res, exp, tmo);
            end
        end
    endtask

    task automatic test_ignore_start();
        int n;
        @(negedge clk);
        start = 1'b1; a = 16'd3; b = 16'd5; signed_op = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1; a = 16'h1234; b = 16'h4321; signed_op = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 40) begin @(negedge clk); n++; end
        total++;
        if (!done || {hi, lo} !== 32'h0000_000F) begin
            bad++;
            $display("FAIL ignore_result: got done=%0b %h want 1 0000000f", done, {hi, lo});
        end
        n = 0;
        repeat (25) begin
            @(negedge clk);
            if (done || busy) n++;
        end
        total++;
        if (n !== 0) begin
            bad++;
            $display("FAIL ignore_second: saw %0d busy/done cycles after result, want 0", n);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] res, exp2;
        int nbusy, ncyc, n;
        bit tmo, partial;
        run_op(16'd1000, 16'd77, 1'b0, res, nbusy, ncyc, tmo);
        total++;
        if (tmo || res !== 32'd77000) begin
            bad++;
            $display("FAIL b2b_first: got %h want %h", res, 32'd77000);
        end
        // still in the DONE cycle: raise start for the next op
        exp2 = ref_mul(16'hFF00, 16'h0123, 1'b1);
        start = 1'b1; a = 16'hFF00; b = 16'h0123; signed_op = 1'b1;
        @(negedge clk);
        start = 1'b0; a = 16'($urandom); b = 16'($urandom);
        n = 1; partial = 0;
        while (!done && n < 40) begin
            if ({hi, lo} !== 32'd77000) partial = 1;
            @(negedge clk);
            n++;
        end
        total++;
        if (partial) begin
            bad++;
            $display("FAIL b2b_hold: hi/lo changed before FIX, want %h held", 32'd77000);
        end
        total++;
        if (!done || n !== 18 || {hi, lo} !== exp2) begin
            bad++;
            $display("FAIL b2b_second: got done=%0b @%0d %h want 1 @18 %h",
                     done, n, {hi, lo}, exp2);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] res;
        int nbusy, ncyc, n;
        bit tmo;
        run_op(16'h1234, 16'h5678, 1'b0, res, nbusy, ncyc, tmo);
        @(negedge clk);
        start = 1'b1; a = 16'd9; b = 16'd9; signed_op = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        total++;
        if ({busy, done, hi, lo} !== 34'd0) begin
            bad++;
            $display("FAIL reset_async: got busy=%0b done=%0b hi=%h lo=%h want all 0",
                     busy, done, hi, lo);
        end
        @(negedge clk);
        reset_n = 1'b1;
        n = 0;
        repeat (25) begin
            @(negedge clk);
            if (done || busy) n++;
        end
        total++;
        if (n !== 0) begin
            bad++;
            $display("FAIL reset_abort: %0d busy/done cycles after reset, want 0", n);
        end
        run_op(16'd2, 16'd2, 1'b0, res, nbusy, ncyc, tmo);
        total++;
        if (tmo || res !== 32'd4) begin
            bad++;
            $display("FAIL reset_after: got %h tmo=%0b want 00000004", res, tmo);
        end
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; signed_op = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        test_reset();
        reset_n = 1'b1;
        test_directed();
        test_random();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
